axis_frame_len_limit: RTL and testbench
=======================================

# axis_frame_len_limit

AXI4-Stream frame length policer that sits directly upstream of the frame-mode AXI-stream FIFO (configured with `DROP_BAD_FRAME` set). It counts beats per frame, truncates frames that exceed a runtime maximum by forcing `tlast` and discarding the remainder, and marks truncated and runt frames bad through `tuser`. Every frame that reaches the FIFO is therefore bounded in length, and the FIFO drops the marked ones. The block has a single registered output stage and runs at full throughput (one beat per cycle).

## Interface
Parameters:
- `DATA_WIDTH`, 8: tdata width.
- `KEEP_ENABLE`, (DATA_WIDTH>8): carry tkeep.
- `KEEP_WIDTH`, (DATA_WIDTH/8): tkeep width.
- `ID_ENABLE`, 0: carry tid.
- `ID_WIDTH`, 8: tid width.
- `DEST_ENABLE`, 0: carry tdest.
- `DEST_WIDTH`, 8: tdest width.
- `USER_WIDTH`, 1: tuser width.
- `USER_BAD_FRAME_VALUE`, 1'b1: tuser value written on a bad frame's last beat.
- `USER_BAD_FRAME_MASK`, 1'b1: tuser bits that are overwritten.
- `LEN_WIDTH`, 16: beat counter and length config width.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  in (tready out)  per parameters  input stream.
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  out (tready in)  per parameters  output stream.
- `cfg_max_len`  in  LEN_WIDTH  maximum beats per frame. 0 means unlimited.
- `cfg_min_len`  in  LEN_WIDTH  minimum beats per frame. 0 or 1 disables the runt check.
- `status_good`  out  1  one-cycle pulse: frame closed with no violation.
- `status_truncated`  out  1  one-cycle pulse: frame was cut at `cfg_max_len`.
- `status_runt`  out  1  one-cycle pulse: frame was shorter than `cfg_min_len`.
- `status_frame_len`  out  LEN_WIDTH  beats forwarded for the last closed frame. Valid when any status pulse is high; holds its value otherwise.

## Operation
- States: PASS (reset state) and DROP.
- The beat counter `cnt` holds the number of beats of the current frame accepted so far. It resets to 0 and clears on frame close.
- Config latch:
  - `cfg_max_len` and `cfg_min_len` are captured on acceptance of a frame's first beat (`cnt==0`).
  - The first beat uses the live values; the rest of the frame uses the latched values.
  - Changes during a frame have no effect on that frame.
- PASS, beat accepted (`s_axis_tvalid && s_axis_tready`); let `n = cnt+1`:
  - **Input tlast=1.** Forward the beat unchanged, except: if `min>1` and `n<min`, overwrite the masked tuser bits and pulse `status_runt`; otherwise pulse `status_good`. Set `status_frame_len=n`, `cnt←0`.
  - **Input tlast=0, `max!=0`, and `n==max`.** Forward with tlast forced to 1 and tuser masked to bad. Pulse `status_truncated`, set `status_frame_len=n`, `cnt←0`, go to DROP.
  - **Otherwise.** Forward unchanged and set `cnt←n`. `cnt` saturates at all-ones and does not wrap.
- Bad tuser value: `(tuser & ~MASK) | (VALUE & MASK)`.
- DROP:
  - `s_axis_tready=1`; beats are discarded and nothing is forwarded.
  - On an accepted beat with tlast=1, return to PASS. There is no status pulse for the discarded tail.
- A frame that ends with tlast exactly at beat `max` is good, not truncated.
- Truncation takes precedence over runt. A frame cannot be both.
- Output register:
  - `s_axis_tready = m_axis_tready || !m_axis_tvalid` in PASS.
  - The register loads on accept. `m_axis_tvalid` clears when the register is drained and no new beat is loaded.
- Reset (any time, including mid-frame or in DROP):
  - State goes to PASS, `cnt=0`, `m_axis_tvalid=0`, all status pulses 0, `status_frame_len=0`.
  - The in-flight output beat is lost. The next input beat starts a new frame.

## Timing
- Latency: input accept at cycle N → beat valid on `m_axis` at cycle N+1.
- Status pulses and `status_frame_len` update at cycle N+1, aligned with the closing beat appearing on `m_axis`.
- Throughput is one beat per cycle with `m_axis_tready` held high.
- DROP consumes one input beat per cycle regardless of `m_axis_tready`.
- Reset values: `m_axis_tvalid=0`, `s_axis_tready=1` (output empty), status outputs 0.
- `m_axis` data/tlast/tuser are stable while `m_axis_tvalid && !m_axis_tready`.

## Test plan
- **Normal frame.** `max=8`, `min=2`; 4-beat frame 0x10..0x13 with tuser=0 → 4 beats out unchanged, tlast on 0x13, `status_good` one pulse, `status_frame_len=4`.
- **Truncation.** `max=3`; 6-beat frame 0x20..0x25 → output 0x20, 0x21, 0x22 with tlast=1 and tuser=1 on 0x22. Beats 0x23..0x25 are accepted with tready=1 and never appear. `status_truncated` pulse, `len=3`. The following 2-beat frame passes as good.
- **Runt and exact max.** `min=4`; 2-beat frame → tuser=1 on the last beat, `status_runt`, `len=2`. Then `max=5` with a 5-beat frame → good, not truncated.
- **Backpressure.** `m_axis_tready` pattern 1,0,0,1,0,1… over a 10-beat frame (`max=0`) → all 10 beats out, in order, no duplicates; output held stable during stalls; `s_axis_tready` low only while output is full and stalled.
- **Edge config.**
  - `max=1` with a 3-beat frame → one beat out with tlast=1 and tuser=1, two beats dropped.
  - `cfg_max_len` changed from 8 to 2 at beat 3 of a 6-beat frame → frame passes whole (latched value applies).
- **Reset mid-DROP.** `max=2`; 8-beat frame, assert `rst` for 1 cycle at beat 4 → `m_axis_tvalid=0`, status outputs 0. The next 3-beat frame forwards fully with `status_good`, `len=3`.

Source files
------------

// File: rtl/axis_frame_len_limit_if.sv
// AXI4-Stream bundle used by axis_frame_len_limit.
//   master modport: drives tdata/tkeep/tvalid/tlast/tid/tdest/tuser, samples tready
//   slave modport : samples tdata/tkeep/tvalid/tlast/tid/tdest/tuser, drives tready
interface axis_frame_len_limit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_len_limit.sv
// AXI4-Stream frame length policer with a single registered output stage.
// Counts beats per frame; a frame reaching cfg_max_len without tlast is cut there
// (tlast forced, tuser marked bad) and its remainder is discarded. Frames closing
// shorter than cfg_min_len get tuser marked bad. Config is captured on each frame's
// first beat.
//   clk, rst          : clock, synchronous active-high reset
//   s_axis            : input stream (slave modport)
//   m_axis            : output stream (master modport)
//   cfg_max_len       : max beats per frame, 0 = unlimited
//   cfg_min_len       : min beats per frame, 0/1 = no runt check
//   status_good/truncated/runt : one-cycle pulses aligned with the closing output beat
//   status_frame_len  : beats forwarded for the last closed frame
module axis_frame_len_limit #(
    parameter int                    DATA_WIDTH           = 8,
    parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
    parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter bit                    ID_ENABLE            = 1'b0,
    parameter int                    ID_WIDTH             = 8,
    parameter bit                    DEST_ENABLE          = 1'b0,
    parameter int                    DEST_WIDTH           = 8,
    parameter int                    USER_WIDTH           = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
    parameter int                    LEN_WIDTH            = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    axis_frame_len_limit_if.slave         s_axis,
    axis_frame_len_limit_if.master        m_axis,
    input  logic [LEN_WIDTH-1:0]          cfg_max_len,
    input  logic [LEN_WIDTH-1:0]          cfg_min_len,
    output logic                          status_good,
    output logic                          status_truncated,
    output logic                          status_runt,
    output logic [LEN_WIDTH-1:0]          status_frame_len
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [0:0] {StPass, StDrop} state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   max_q, max_d;
    logic [LEN_WIDTH-1:0]   min_q, min_d;

    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic [ID_WIDTH-1:0]    tid_q, tid_d;
    logic [DEST_WIDTH-1:0]  tdest_q, tdest_d;
    logic [USER_WIDTH-1:0]  tuser_q, tuser_d;

    logic                   good_q, good_d;
    logic                   trunc_q, trunc_d;
    logic                   runt_q, runt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;

    logic                   s_ready;
    logic                   accept;
    logic                   first_beat;
    logic [LEN_WIDTH-1:0]   eff_max;
    logic [LEN_WIDTH-1:0]   eff_min;
    logic [LEN_WIDTH-1:0]   n;
    logic [USER_WIDTH-1:0]  bad_user;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        min_d    = min_q;
        valid_d  = valid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        tuser_d  = tuser_q;
        good_d   = 1'b0;
        trunc_d  = 1'b0;
        runt_d   = 1'b0;
        len_d    = len_q;

        // DROP sinks beats unconditionally; PASS only when the output slot frees up.
        s_ready  = (state_q == StDrop) ? 1'b1 : (m_axis.tready || !valid_q);
        accept   = s_axis.tvalid && s_ready;

        // First beat of a frame sees the live config, later beats the captured copy.
        first_beat = (cnt_q == '0);
        eff_max    = first_beat ? cfg_max_len : max_q;
        eff_min    = first_beat ? cfg_min_len : min_q;
        n          = (cnt_q == '1) ? cnt_q : cnt_q + LEN_ONE;
        bad_user   = (s_axis.tuser & ~USER_BAD_FRAME_MASK)
                   | (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);

        if (m_axis.tready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                StPass: begin
                    if (first_beat) begin
                        max_d = cfg_max_len;
                        min_d = cfg_min_len;
                    end
                    valid_d = 1'b1;
                    tdata_d = s_axis.tdata;
                    tkeep_d = KEEP_ENABLE ? s_axis.tkeep : '1;
                    tid_d   = ID_ENABLE ? s_axis.tid : '0;
                    tdest_d = DEST_ENABLE ? s_axis.tdest : '0;
                    tuser_d = s_axis.tuser;
                    tlast_d = s_axis.tlast;
                    if (s_axis.tlast) begin
                        // A frame ending exactly at max lands here: good, not truncated.
                        if (eff_min > LEN_ONE && n < eff_min) begin
                            tuser_d = bad_user;
                            runt_d  = 1'b1;
                        end else begin
                            good_d  = 1'b1;
                        end
                        len_d = n;
                        cnt_d = '0;
                    end else if (eff_max != '0 && n == eff_max) begin
                        tlast_d = 1'b1;
                        tuser_d = bad_user;
                        trunc_d = 1'b1;
                        len_d   = n;
                        cnt_d   = '0;
                        state_d = StDrop;
                    end else begin
                        cnt_d = n;
                    end
                end
                StDrop: begin
                    if (s_axis.tlast) begin
                        state_d = StPass;
                    end
                end
                default: state_d = StPass;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StPass;
            cnt_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            valid_q <= 1'b0;
            good_q  <= 1'b0;
            trunc_q <= 1'b0;
            runt_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            min_q   <= min_d;
            valid_q <= valid_d;
            good_q  <= good_d;
            trunc_q <= trunc_d;
            runt_q  <= runt_d;
            len_q   <= len_d;
        end
    end

    // Payload needs no reset; it is qualified by valid_q.
    always_ff @(posedge clk) begin
        tdata_q <= tdata_d;
        tkeep_q <= tkeep_d;
        tlast_q <= tlast_d;
        tid_q   <= tid_d;
        tdest_q <= tdest_d;
        tuser_q <= tuser_d;
    end

    assign s_axis.tready    = s_ready;
    assign m_axis.tvalid    = valid_q;
    assign m_axis.tdata     = tdata_q;
    assign m_axis.tkeep     = tkeep_q;
    assign m_axis.tlast     = tlast_q;
    assign m_axis.tid       = tid_q;
    assign m_axis.tdest     = tdest_q;
    assign m_axis.tuser     = tuser_q;

    assign status_good      = good_q;
    assign status_truncated = trunc_q;
    assign status_runt      = runt_q;
    assign status_frame_len = len_q;

endmodule

// File: tb/tb_axis_frame_len_limit.sv
// Self-checking bench for axis_frame_len_limit: directed scenarios followed by
// random frames, checked against a frame-level reference model.
module tb_axis_frame_len_limit;

    localparam int UW = 2;

    typedef struct {
        logic [7:0]    data;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct {
        logic [2:0]  kind;  // {runt, truncated, good}
        logic [15:0] len;
    } stat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_max_len;
    logic [15:0] cfg_min_len;
    logic        status_good;
    logic        status_truncated;
    logic        status_runt;
    logic [15:0] status_frame_len;

    axis_frame_len_limit_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8),
                              .USER_WIDTH(UW)) s_if ();
    axis_frame_len_limit_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8),
                              .USER_WIDTH(UW)) m_if ();

    axis_frame_len_limit #(
        .DATA_WIDTH(8), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(1), .ID_ENABLE(1'b0), .ID_WIDTH(8),
        .DEST_ENABLE(1'b0), .DEST_WIDTH(8), .USER_WIDTH(UW),
        .USER_BAD_FRAME_VALUE(2'b01), .USER_BAD_FRAME_MASK(2'b01), .LEN_WIDTH(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .cfg_max_len      (cfg_max_len),
        .cfg_min_len      (cfg_min_len),
        .status_good      (status_good),
        .status_truncated (status_truncated),
        .status_runt      (status_runt),
        .status_frame_len (status_frame_len)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    passed = 0;
    bit    mon_en = 1'b0;
    int    bp_mode = 0;
    beat_t exp_q[$];
    stat_t st_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [UW-1:0] bad(input logic [UW-1:0] u);
        return (u & 2'b10) | 2'b01;
    endfunction

    // Output-ready generator: always ready, fixed 1,0,0,1,0,1 pattern, or random.
    initial begin
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int idx = 0;
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       m_if.tready = 1'b1;
                1: begin
                    m_if.tready = pat[idx % 6];
                    idx++;
                end
                default: m_if.tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output monitor: beats, status pulses, stall stability, tready rule.
    initial begin
        bit            prev_stall = 1'b0;
        logic [7:0]    prev_data;
        logic          prev_last;
        logic [UW-1:0] prev_user;
        beat_t         e;
        stat_t         s;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_if.tvalid, 1'b1);
                    check("hold_data", m_if.tdata, prev_data);
                    check("hold_last", m_if.tlast, prev_last);
                    check("hold_user", m_if.tuser, prev_user);
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_data  = m_if.tdata;
                prev_last  = m_if.tlast;
                prev_user  = m_if.tuser;
                if (m_if.tvalid && m_if.tready) begin
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", m_if.tdata, e.data);
                        check("out_last", m_if.tlast, e.last);
                        check("out_user", m_if.tuser, e.user);
                    end
                end
                if (status_good || status_truncated || status_runt) begin
                    check("status_expected", st_q.size() != 0, 1'b1);
                    if (st_q.size() != 0) begin
                        s = st_q.pop_front();
                        check("status_kind", {status_runt, status_truncated, status_good},
                              s.kind);
                        check("status_len", status_frame_len, s.len);
                    end
                end
                if (!s_if.tready) begin
                    check("tready_low_only_when_stalled", m_if.tvalid && !m_if.tready, 1'b1);
                end
            end
        end
    end

    task automatic wait_accept();
        bit acc = 1'b0;
        int guard = 0;
        do begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("accept_timeout", acc, 1'b1);
    endtask

    // Sends a frame and queues what the model says must come out. base < 0 gives random
    // data; chg_beat switches the live config while that beat is presented.
    task automatic send_frame(input int len, input int base, input int mx, input int mn,
                              input int chg_beat, input int chg_max, input int chg_min,
                              input int stop_at, input bit rnd);
        logic [7:0]    d[$];
        logic [UW-1:0] u[$];
        int            out_n;
        bit            trunc;
        bit            runt;
        beat_t         b;
        stat_t         s;
        for (int i = 0; i < len; i++) begin
            d.push_back(base < 0 ? 8'($urandom) : 8'(base + i));
            u.push_back(rnd ? UW'($urandom_range(0, 3)) : '0);
        end
        trunc = (mx != 0) && (len > mx);
        runt  = !trunc && (mn > 1) && (len < mn);
        out_n = trunc ? mx : len;
        for (int i = 0; i < out_n; i++) begin
            b.data = d[i];
            b.last = (i == out_n - 1);
            b.user = (b.last && (trunc || runt)) ? bad(u[i]) : u[i];
            exp_q.push_back(b);
        end
        s.kind = trunc ? 3'b010 : (runt ? 3'b100 : 3'b001);
        s.len  = 16'(out_n);
        st_q.push_back(s);

        cfg_max_len = 16'(mx);
        cfg_min_len = 16'(mn);
        for (int i = 0; i < stop_at; i++) begin
            if (i == chg_beat) begin
                cfg_max_len = 16'(chg_max);
                cfg_min_len = 16'(chg_min);
            end
            if (rnd) begin
                s_if.tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = d[i];
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = u[i];
            wait_accept();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || st_q.size() != 0) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("drain_beats_left", exp_q.size(), 0);
        check("drain_status_left", st_q.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_m_tvalid"}, m_if.tvalid, 1'b0);
        check({tag, "_s_tready"}, s_if.tready, 1'b1);
        check({tag, "_status"}, {status_runt, status_truncated, status_good}, 3'b000);
        check({tag, "_len"}, status_frame_len, 16'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        s_if.tuser  = '0;
        cfg_max_len = '0;
        cfg_min_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        // Normal 4-beat frame.
        send_frame(4, 'h10, 8, 2, -1, 0, 0, 4, 1'b0);
        drain();
        // Truncation at 3, then a short good frame.
        send_frame(6, 'h20, 3, 0, -1, 0, 0, 6, 1'b0);
        send_frame(2, 'h30, 3, 0, -1, 0, 0, 2, 1'b0);
        drain();
        // Runt, then a frame ending exactly at max.
        send_frame(2, 'h40, 0, 4, -1, 0, 0, 2, 1'b0);
        send_frame(5, 'h48, 5, 0, -1, 0, 0, 5, 1'b0);
        drain();
        // Backpressure pattern over an unlimited 10-beat frame.
        bp_mode = 1;
        send_frame(10, 'h50, 0, 0, -1, 0, 0, 10, 1'b0);
        drain();
        bp_mode = 0;
        // max=1, then a mid-frame config change that must not apply.
        send_frame(3, 'h60, 1, 0, -1, 0, 0, 3, 1'b0);
        send_frame(6, 'h70, 8, 0, 2, 2, 0, 6, 1'b0);
        drain();

        // Reset while discarding a truncated frame's tail.
        send_frame(8, 'h80, 2, 0, -1, 0, 0, 4, 1'b0);
        drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("mid_drop_reset");
        send_frame(3, 'h90, 0, 0, -1, 0, 0, 3, 1'b0);
        drain();

        // Random frames, random gaps, random backpressure, random mid-frame config changes.
        bp_mode = 2;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 12);
            send_frame(len, -1, $urandom_range(0, 8), $urandom_range(0, 8),
                       $urandom_range(1, len), $urandom_range(0, 8), $urandom_range(0, 8),
                       len, 1'b1);
        end
        drain();
        bp_mode = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
